// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller for the 5-stage CPU
//
// Purpose: resolves the hazards the forwarding unit cannot. These are
// load-use (one-cycle stall plus bubble), a taken branch resolved in EX
// (IF/ID and ID/EX flush), and a multi-cycle MUL/DIV in EX (counted freeze).
// It also keeps saturating stall and flush performance counters.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-low reset
//   ID_rs_addr/ID_rt_addr source registers of the instruction in ID
//   ID_uses_rt            ID instruction reads rt
//   EX_dst_addr           destination register of the instruction in EX
//   EX_mem_read           EX instruction is a load
//   EX_mdu_op             EX instruction is MUL/DIV
//   EX_branch_tkn         branch in EX resolved taken
//   pc_write, if_id_write, id_ex_write   pipeline write enables
//   if_id_flush, id_ex_flush             flushes (NOP / bubble)
//   ex_mem_bubble         EX/MEM loads bubble while MDU result is not ready
//   mdu_busy              MDU freeze in progress (after the issue cycle)
//   stall_cnt, flush_cnt  saturating performance counters
module hazard_ctrl #(
  parameter int MDU_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs_addr,
  input  logic [4:0]       ID_rt_addr,
  input  logic             ID_uses_rt,
  input  logic [4:0]       EX_dst_addr,
  input  logic             EX_mem_read,
  input  logic             EX_mdu_op,
  input  logic             EX_branch_tkn,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {S_RUN, S_MDU_BUSY} state_t;

  // The issue cycle is spent in RUN and the release cycle is counter==0,
  // so the busy countdown starts two below the total EX occupancy.
  localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;
  logic             stall_evt;
  logic             flush_evt;

  // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
  always_comb begin
    load_use = EX_mem_read && (EX_dst_addr != 5'd0) &&
               ((EX_dst_addr == ID_rs_addr) ||
                (ID_uses_rt && (EX_dst_addr == ID_rt_addr)));
  end

  always_comb begin
    state_d       = state_q;
    mdu_cnt_d     = mdu_cnt_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mdu_busy      = 1'b0;
    flush_evt     = 1'b0;

    case (state_q)
      S_RUN: begin
        if (EX_mdu_op) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          mdu_cnt_d     = MDU_LOAD;
          state_d       = S_MDU_BUSY;
        end else if (EX_branch_tkn) begin
          // The ID instruction is wrong-path, so any load-use on it is moot.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_evt   = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      S_MDU_BUSY: begin
        // EX still holds the MDU op, so branch and load-use inputs are ignored.
        if (mdu_cnt_q != 4'd0) begin
          mdu_busy      = 1'b1;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          mdu_cnt_d     = mdu_cnt_q - 4'd1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase

    stall_evt = !pc_write;

    // While reset is asserted every enable and flush is forced low.
    if (!rst_i) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      mdu_busy      = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_evt && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush_evt && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_RUN;
      mdu_cnt_q   <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  ID_rs_addr = '0;
  logic [4:0]  ID_rt_addr = '0;
  logic        ID_uses_rt = 1'b0;
  logic [4:0]  EX_dst_addr = '0;
  logic        EX_mem_read = 1'b0;
  logic        EX_mdu_op = 1'b0;
  logic        EX_branch_tkn = 1'b0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic        ex_mem_bubble, mdu_busy;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MDU_CYCLES(4), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_rs_addr(ID_rs_addr), .ID_rt_addr(ID_rt_addr), .ID_uses_rt(ID_uses_rt),
    .EX_dst_addr(EX_dst_addr), .EX_mem_read(EX_mem_read), .EX_mdu_op(EX_mdu_op),
    .EX_branch_tkn(EX_branch_tkn),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk_i = ~clk_i;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, mdu_busy}
  logic [6:0] outs_v;
  assign outs_v = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                   ex_mem_bubble, mdu_busy};

  localparam logic [6:0] O_DEF  = 7'b1101000;
  localparam logic [6:0] O_LU   = 7'b0001100;
  localparam logic [6:0] O_BR   = 7'b1111100;
  localparam logic [6:0] O_MDUI = 7'b0000010;
  localparam logic [6:0] O_BUSY = 7'b0000011;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] dst;
    logic       mem_rd;
    logic       mdu;
    logic       br;
  } stim_t;

  typedef struct {
    logic [6:0]  outs;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_stall = '0;
  logic [15:0] model_flush = '0;

  function automatic stim_t mk(input int rs, input int rt, input bit uses, input int dst,
                               input bit rd, input bit mdu, input bit br);
    stim_t s;
    s.rs = 5'(rs); s.rt = 5'(rt); s.uses_rt = uses; s.dst = 5'(dst);
    s.mem_rd = rd; s.mdu = mdu; s.br = br;
    return s;
  endfunction

  // Apply one cycle of stimulus and queue the outputs and counters it must produce.
  task automatic drive(input stim_t s, input logic [6:0] o);
    exp_t e;
    ID_rs_addr = s.rs; ID_rt_addr = s.rt; ID_uses_rt = s.uses_rt;
    EX_dst_addr = s.dst; EX_mem_read = s.mem_rd; EX_mdu_op = s.mdu; EX_branch_tkn = s.br;
    if (!o[6] && model_stall != 16'hFFFF) model_stall = model_stall + 16'd1;
    if (o[4] && model_flush != 16'hFFFF) model_flush = model_flush + 16'd1;
    e.outs = o; e.stall = model_stall; e.flush = model_flush;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    drive(mk(0, 0, 0, 0, 0, 0, 0), O_DEF);
    sb.delete();
    rst_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_stall = '0;
    model_flush = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    #1;
    checks++;
    if (outs_v !== 7'b0) begin
      errors++; $display("FAIL reset_outs got %b exp %b", outs_v, 7'b0);
    end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %h/%h exp 0000/0000", stall_cnt, flush_cnt);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0), O_DEF);
      #4; e = sb.pop_front(); checks++;
      if (outs_v !== e.outs) begin
        errors++; $display("FAIL reset_release cyc%0d outs got %b exp %b", i, outs_v, e.outs);
      end
      @(posedge clk_i); #1; checks++;
      if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        errors++; $display("FAIL reset_release cyc%0d cnt got %h/%h exp %h/%h", i,
                           stall_cnt, flush_cnt, e.stall, e.flush);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_load_use();
    stim_t      st[4];
    logic [6:0] ex[4];
    exp_t       e;
    do_reset();
    st = '{mk(2, 9, 1, 2, 1, 0, 0), mk(2, 9, 1, 0, 0, 0, 0),
           mk(1, 7, 1, 7, 1, 0, 0), mk(0, 0, 0, 0, 0, 0, 0)};
    ex = '{O_LU, O_DEF, O_LU, O_DEF};
    for (int i = 0; i < 4; i++) begin
      drive(st[i], ex[i]);
      #4; e = sb.pop_front(); checks++;
      if (outs_v !== e.outs) begin
        errors++; $display("FAIL load_use cyc%0d outs got %b exp %b", i, outs_v, e.outs);
      end
      @(posedge clk_i); #1; checks++;
      if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        errors++; $display("FAIL load_use cyc%0d cnt got %h/%h exp %h/%h", i,
                           stall_cnt, flush_cnt, e.stall, e.flush);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_no_stall();
    stim_t      st[3];
    logic [6:0] ex[3];
    exp_t       e;
    do_reset();
    st = '{mk(0, 0, 1, 0, 1, 0, 0), mk(1, 5, 0, 5, 1, 0, 0), mk(3, 3, 1, 3, 0, 0, 0)};
    ex = '{O_DEF, O_DEF, O_DEF};
    for (int i = 0; i < 3; i++) begin
      drive(st[i], ex[i]);
      #4; e = sb.pop_front(); checks++;
      if (outs_v !== e.outs) begin
        errors++; $display("FAIL no_stall cyc%0d outs got %b exp %b", i, outs_v, e.outs);
      end
      @(posedge clk_i); #1; checks++;
      if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        errors++; $display("FAIL no_stall cyc%0d cnt got %h/%h exp %h/%h", i,
                           stall_cnt, flush_cnt, e.stall, e.flush);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_mdu();
    stim_t      st[5];
    logic [6:0] ex[5];
    exp_t       e;
    do_reset();
    // Cycle 1 also presents a taken branch and a load-use, which the busy FSM must ignore.
    st = '{mk(0, 0, 0, 4, 0, 1, 0), mk(2, 0, 0, 2, 1, 1, 1), mk(0, 0, 0, 4, 0, 1, 0),
           mk(0, 0, 0, 4, 0, 1, 0), mk(0, 0, 0, 0, 0, 0, 0)};
    ex = '{O_MDUI, O_BUSY, O_BUSY, O_DEF, O_DEF};
    for (int i = 0; i < 5; i++) begin
      drive(st[i], ex[i]);
      #4; e = sb.pop_front(); checks++;
      if (outs_v !== e.outs) begin
        errors++; $display("FAIL mdu cyc%0d outs got %b exp %b", i, outs_v, e.outs);
      end
      @(posedge clk_i); #1; checks++;
      if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        errors++; $display("FAIL mdu cyc%0d cnt got %h/%h exp %h/%h", i,
                           stall_cnt, flush_cnt, e.stall, e.flush);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ex[9];
    exp_t       e;
    do_reset();
    ex = '{O_MDUI, O_BUSY, O_BUSY, O_DEF, O_MDUI, O_BUSY, O_BUSY, O_DEF, O_DEF};
    for (int i = 0; i < 9; i++) begin
      drive(mk(0, 0, 0, 4, 0, (i < 8) ? 1'b1 : 1'b0, 0), ex[i]);
      #4; e = sb.pop_front(); checks++;
      if (outs_v !== e.outs) begin
        errors++; $display("FAIL back_to_back cyc%0d outs got %b exp %b", i, outs_v, e.outs);
      end
      @(posedge clk_i); #1; checks++;
      if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        errors++; $display("FAIL back_to_back cyc%0d cnt got %h/%h exp %h/%h", i,
                           stall_cnt, flush_cnt, e.stall, e.flush);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_branch();
    stim_t      st[4];
    logic [6:0] ex[4];
    exp_t       e;
    do_reset();
    // Branch with a simultaneous load-use, a plain branch, then MDU winning over branch.
    st = '{mk(2, 0, 0, 2, 1, 0, 1), mk(0, 0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 0, 0),
           mk(0, 0, 0, 0, 0, 1, 1)};
    ex = '{O_BR, O_BR, O_DEF, O_MDUI};
    for (int i = 0; i < 4; i++) begin
      drive(st[i], ex[i]);
      #4; e = sb.pop_front(); checks++;
      if (outs_v !== e.outs) begin
        errors++; $display("FAIL branch cyc%0d outs got %b exp %b", i, outs_v, e.outs);
      end
      @(posedge clk_i); #1; checks++;
      if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        errors++; $display("FAIL branch cyc%0d cnt got %h/%h exp %h/%h", i,
                           stall_cnt, flush_cnt, e.stall, e.flush);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset_mid_mdu();
    exp_t e;
    do_reset();
    drive(mk(0, 0, 0, 4, 0, 1, 0), O_MDUI);
    #4; e = sb.pop_front(); checks++;
    if (outs_v !== e.outs) begin
      errors++; $display("FAIL mid_rst issue outs got %b exp %b", outs_v, e.outs);
    end
    @(negedge clk_i);
    #1; checks++;
    if (outs_v !== O_BUSY) begin
      errors++; $display("FAIL mid_rst busy outs got %b exp %b", outs_v, O_BUSY);
    end
    rst_i = 1'b0;
    #1; checks++;
    if (outs_v !== 7'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_rst async got %b %h/%h exp 0000000 0000/0000",
                         outs_v, stall_cnt, flush_cnt);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_stall = '0;
    model_flush = '0;
    for (int i = 0; i < 3; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0), O_DEF);
      #4; e = sb.pop_front(); checks++;
      if (outs_v !== e.outs) begin
        errors++; $display("FAIL mid_rst after cyc%0d outs got %b exp %b", i, outs_v, e.outs);
      end
      @(posedge clk_i); #1; checks++;
      if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        errors++; $display("FAIL mid_rst after cyc%0d cnt got %h/%h exp %h/%h", i,
                           stall_cnt, flush_cnt, e.stall, e.flush);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    do_reset();
    ID_rs_addr = 5'd3; EX_dst_addr = 5'd3; EX_mem_read = 1'b1;
    repeat (65534) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_preload got %h exp %h", stall_cnt, 16'hFFFE);
    end
    model_stall = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      drive(mk(3, 0, 0, 3, 1, 0, 0), O_LU);
      #4; e = sb.pop_front(); checks++;
      if (outs_v !== e.outs) begin
        errors++; $display("FAIL saturate cyc%0d outs got %b exp %b", i, outs_v, e.outs);
      end
      @(posedge clk_i); #1; checks++;
      if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        errors++; $display("FAIL saturate cyc%0d cnt got %h/%h exp %h/%h", i,
                           stall_cnt, flush_cnt, e.stall, e.flush);
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_mdu();
    test_back_to_back();
    test_branch();
    test_reset_mid_mdu();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
